// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/branch sequencer for the simpleRISC core.
// Owns pc and ir. Fetches from instruction memory and hands non-branch
// instructions to the datapath controller (exec_start/exec_done). Sequences
// B/Bcond, BL, BX and BLX by loading pc from the branch-target unit, and
// drives the R7 link write for BL/BLX.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   mem_rdata  in   [15:0] instruction read data, valid the cycle after mem_rd rises
//   next_pc    in   [8:0]  branch target from the PC-update unit
//   exec_done  in   datapath finished current instruction (sampled in EXEC only)
//   mem_addr   out  [8:0]  instruction address (= pc)
//   mem_rd     out  instruction read strobe
//   pc         out  [8:0]  program counter
//   ir         out  [15:0] instruction register
//   exec_start out  one-cycle datapath start pulse
//   link_we    out  R7 write enable
//   link_data  out  [8:0]  R7 write data (= pc)
//   halted     out  high while in HALT
module pc_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_rdata,
    input  logic [8:0]  next_pc,
    input  logic        exec_done,
    output logic [8:0]  mem_addr,
    output logic        mem_rd,
    output logic [8:0]  pc,
    output logic [15:0] ir,
    output logic        exec_start,
    output logic        link_we,
    output logic [8:0]  link_data,
    output logic        halted
);

    localparam int unsigned PC_W = 9;

    typedef enum logic [3:0] {
        S_RST,
        S_IF1,
        S_IF2,
        S_UPDATE,
        S_DECODE,
        S_EXEC,
        S_LINK,
        S_BRANCH,
        S_HALT
    } state_t;

    // Where EXEC goes once the datapath reports done; chosen in DECODE.
    typedef enum logic [1:0] {
        AFTER_IF1,
        AFTER_LINK,
        AFTER_BRANCH
    } after_t;

    state_t state;
    after_t exec_next;

    logic [2:0] opcode;
    logic [1:0] op;
    logic       is_halt;
    logic       is_bcond;
    logic       is_bl;
    logic       is_bx;
    logic       is_blx;

    // Instruction classification from the latched ir.
    assign opcode   = ir[15:13];
    assign op       = ir[12:11];
    assign is_halt  = (opcode == 3'b111);
    assign is_bcond = (opcode == 3'b001) && (op == 2'b00);
    assign is_bl    = (opcode == 3'b010) && (op == 2'b11);
    assign is_bx    = (opcode == 3'b010) && (op == 2'b00);
    assign is_blx   = (opcode == 3'b010) && (op == 2'b10);

    assign mem_addr  = pc;
    assign link_data = pc;

    // Sequencer FSM. Moore outputs are registered: each transition loads the
    // strobe values belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_RST;
            exec_next  <= AFTER_IF1;
            pc         <= '0;
            ir         <= '0;
            mem_rd     <= 1'b0;
            exec_start <= 1'b0;
            link_we    <= 1'b0;
            halted     <= 1'b0;
        end else begin
            mem_rd     <= 1'b0;
            exec_start <= 1'b0;
            link_we    <= 1'b0;
            halted     <= 1'b0;

            case (state)
                S_RST: begin
                    state  <= S_IF1;
                    mem_rd <= 1'b1;
                end

                S_IF1: begin
                    state  <= S_IF2;
                    mem_rd <= 1'b1;
                end

                S_IF2: begin
                    ir    <= mem_rdata;
                    state <= S_UPDATE;
                end

                S_UPDATE: begin
                    pc    <= pc + PC_W'(1);
                    state <= S_DECODE;
                end

                S_DECODE: begin
                    if (is_halt) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (is_bcond) begin
                        state <= S_BRANCH;
                    end else if (is_bl) begin
                        state   <= S_LINK;
                        link_we <= 1'b1;
                    end else begin
                        // BX/BLX need Rd from the datapath before branching.
                        state      <= S_EXEC;
                        exec_start <= 1'b1;
                        if (is_bx) begin
                            exec_next <= AFTER_BRANCH;
                        end else if (is_blx) begin
                            exec_next <= AFTER_LINK;
                        end else begin
                            exec_next <= AFTER_IF1;
                        end
                    end
                end

                S_EXEC: begin
                    if (exec_done) begin
                        case (exec_next)
                            AFTER_LINK: begin
                                state   <= S_LINK;
                                link_we <= 1'b1;
                            end
                            AFTER_BRANCH: begin
                                state <= S_BRANCH;
                            end
                            default: begin
                                state  <= S_IF1;
                                mem_rd <= 1'b1;
                            end
                        endcase
                    end
                end

                S_LINK: begin
                    state <= S_BRANCH;
                end

                S_BRANCH: begin
                    pc     <= next_pc;
                    state  <= S_IF1;
                    mem_rd <= 1'b1;
                end

                S_HALT: begin
                    halted <= 1'b1;
                end

                default: begin
                    state <= S_RST;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/branch sequencer for the simpleRISC core. Owns the program counter and instruction register, runs the instruction-fetch FSM against instruction memory, and hands non-branch instructions to the datapath controller through a start/done handshake. Sequences branch-class instructions (B/Bcond, BL, BX, BLX) by loading the PC from the branch-target unit. Drives the R7 link write for BL/BLX.

## Interface
- No parameters. Widths are fixed: PC 9 bits, instruction 16 bits.
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high.
- mem_rdata  in  16  instruction-memory read data; valid in the cycle after mem_rd rises.
- next_pc  in  9  branch target from the PC-update unit, computed combinationally from pc, ir, flags and datapath_out.
- exec_done  in  1  datapath controller finished the current instruction; sampled only in EXEC.
- mem_addr  out  9  instruction-memory address; equals pc.
- mem_rd  out  1  instruction-memory read strobe.
- pc  out  9  program counter register.
- ir  out  16  instruction register; fields are opcode=ir[15:13], op=ir[12:11], cond=ir[10:8], im8=ir[7:0].
- exec_start  out  1  one-cycle pulse that starts the datapath controller on ir.
- link_we  out  1  R7 write enable.
- link_data  out  9  value written to R7; equals pc.
- halted  out  1  high while in HALT.

## Operation
- States: RST, IF1, IF2, UPDATE, DECODE, EXEC, LINK, BRANCH, HALT. All outputs except pc, ir and mem_addr are decoded from the state (Moore).
- RST: all strobes are 0. Goes to IF1 when reset is low.
- IF1: mem_rd=1. Goes to IF2.
- IF2: mem_rd=1, ir<=mem_rdata. Goes to UPDATE.
- UPDATE: pc<=pc+1, modulo 512 (511 wraps to 0). Goes to DECODE.
- DECODE: classifies ir.
  - opcode 111 → HALT.
  - opcode 001, op 00 (B, BEQ, BNE, BLT, BLE) → BRANCH. next_pc already resolves taken/not-taken; not-taken yields pc.
  - opcode 010, op 11 (BL) → LINK, then BRANCH.
  - opcode 010, op 00 (BX) → EXEC, then BRANCH.
  - opcode 010, op 10 (BLX) → EXEC, then LINK, then BRANCH.
  - anything else → EXEC, then IF1. This includes undefined encodings; the datapath owns their decode.
- EXEC: exec_start=1 in the first EXEC cycle only. Stays in EXEC until exec_done=1, then moves to the successor chosen in DECODE. For BX/BLX, the datapath holds datapath_out (the Rd value) stable until the next exec_start. This is what lets next_pc stay valid through LINK and BRANCH.
- LINK: link_we=1, link_data=pc (the address of the instruction after the BL). Goes to BRANCH. For BLX, Rd is read in EXEC before R7 is written, so BLX R7 jumps to the old R7.
- BRANCH: pc<=next_pc. Goes to IF1.
- HALT: halted=1, all strobes 0, pc and ir frozen. Leaves only on reset.
- Only UPDATE and BRANCH write pc. Only IF2 writes ir.

## Timing
- Reset (synchronous): state=RST, pc=0, ir=0, mem_rd=0, exec_start=0, link_we=0, halted=0. mem_addr=0.
- Reset asserted in any state, including mid-EXEC or HALT, takes effect at the next edge. Any pending exec_done is dropped; the datapath controller shares the same reset.
- After reset deasserts: RST → IF1 on the next edge, so the first fetch is from address 0.
- Cycles per instruction, counted from IF1 entry to the next IF1 entry:
  - conditional branch: 5.
  - BL: 6.
  - ALU/memory instruction: 4 + n, where n ≥ 1 is the number of EXEC cycles. exec_done=1 in the same cycle as exec_start gives n=1.
  - BX: 5 + n.
  - BLX: 6 + n.
- exec_done outside EXEC is ignored. exec_done held high across two instructions does not skip the second exec_start.
- A branch target of 511, or pc wrap in UPDATE, needs no special handling; arithmetic is 9-bit modulo.

## Test plan
- Reset then straight-line code: memory holds ALU ops at 0–2, bench returns exec_done one cycle after exec_start. Required: mem_addr sequence 0, 1, 2, and exactly one exec_start pulse per instruction. At the first DECODE, pc=1.
- Conditional branch at address 5 with bench next_pc=0x0A. Required: pc=0x0A exactly 5 cycles after IF1 at address 5. With next_pc=6 (not taken), the next fetch is from 6.
- BL at address 0x10 with next_pc=0x40. Required: link_we=1 for one cycle with link_data=0x11, then the next fetch is from 0x40.
- BX with exec_done delayed 3 cycles and next_pc=0x1FF, then an ALU op at 0x1FF. Required: no pc change before exec_done, pc=0x1FF after BRANCH, and pc wraps to 0 in the following UPDATE.
- HALT at address 3. Required: halted=1, no further mem_rd/exec_start/link_we for ≥20 cycles, pc=4.
- Reset asserted during EXEC of a stalled instruction. Required: after the next edge, state outputs match the reset values and pc=0, and the next fetch is from 0.
